// File: rtl/serial_subtractor_pkg.sv
// Shared definitions for the serial subtractor slice.
//   DEFAULT_BITWIDTH : default operand/result width
//   DEFAULT_CHUNK    : default bits processed per RUN cycle
//   state_t          : control FSM states (IDLE, RUN, DONE)
package serial_subtractor_pkg;

   localparam int unsigned DEFAULT_BITWIDTH = 8;
   localparam int unsigned DEFAULT_CHUNK    = 2;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DONE
   } state_t;

endpackage

// File: rtl/serial_subtractor_sub_chunk.sv
// Combinational CHUNK-bit subtract slice: diff = a - b - borrow_in (mod 2^CHUNK),
// borrow_out = (a < b + borrow_in).
//   a, b       : CHUNK-bit operand slices
//   borrow_in  : borrow from the less significant chunk
//   diff       : CHUNK-bit difference slice
//   borrow_out : borrow into the next chunk
module sub_chunk #(
   parameter int unsigned CHUNK = 2
) (
   input  logic [CHUNK-1:0] a,
   input  logic [CHUNK-1:0] b,
   input  logic             borrow_in,
   output logic [CHUNK-1:0] diff,
   output logic             borrow_out
);

   logic [CHUNK:0] wide;

   // One extra bit: the result is negative (top bit set) exactly when a borrow occurs.
   always_comb begin
      wide       = {1'b0, a} - {1'b0, b} - {{CHUNK{1'b0}}, borrow_in};
      diff       = wide[CHUNK-1:0];
      borrow_out = wide[CHUNK];
   end

endmodule

// File: rtl/serial_subtractor.sv
// Multi-cycle subtractor: computes bits_a - bits_b - borrow_in, CHUNK bits per
// cycle LSB first, with valid/ready handshakes on both sides.
//   clk, rst            : clock, synchronous active-high reset
//   bits_a, bits_b      : minuend / subtrahend (captured in IDLE on in_valid)
//   borrow_in           : incoming borrow
//   in_valid / in_ready : input handshake (ready only in IDLE)
//   diff                : result, modulo 2^BITWIDTH
//   borrow_out          : unsigned borrow (bits_a < bits_b + borrow_in)
//   zero                : diff == 0
//   overflow            : signed two's-complement overflow
//   out_valid/out_ready : output handshake (valid only in DONE)
module serial_subtractor
   import serial_subtractor_pkg::*;
#(
   parameter int unsigned BITWIDTH = DEFAULT_BITWIDTH,
   parameter int unsigned CHUNK    = DEFAULT_CHUNK
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [BITWIDTH-1:0] bits_a,
   input  logic [BITWIDTH-1:0] bits_b,
   input  logic                borrow_in,
   input  logic                in_valid,
   output logic                in_ready,
   output logic [BITWIDTH-1:0] diff,
   output logic                borrow_out,
   output logic                zero,
   output logic                overflow,
   output logic                out_valid,
   input  logic                out_ready
);

   localparam int unsigned N     = BITWIDTH / CHUNK;
   localparam int unsigned CNT_W = (N > 1) ? $clog2(N) : 1;
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N - 1);
   localparam int unsigned MSB   = BITWIDTH - 1;

   if ((BITWIDTH % CHUNK) != 0) begin : g_bad_chunk
      $error("serial_subtractor: BITWIDTH must be a multiple of CHUNK");
   end

   state_t              state, state_nxt;
   logic [BITWIDTH-1:0] a_reg, b_reg, diff_reg;
   logic                borrow_reg;
   logic [CNT_W-1:0]    cnt;

   logic [CHUNK-1:0]    a_chunk, b_chunk, d_chunk;
   logic                borrow_nxt;

   always_comb begin
      a_chunk = a_reg[cnt*CHUNK +: CHUNK];
      b_chunk = b_reg[cnt*CHUNK +: CHUNK];
   end

   sub_chunk #(
      .CHUNK (CHUNK)
   ) u_sub_chunk (
      .a          (a_chunk),
      .b          (b_chunk),
      .borrow_in  (borrow_reg),
      .diff       (d_chunk),
      .borrow_out (borrow_nxt)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (in_valid)           state_nxt = RUN;
         RUN:     if (cnt == LAST_CNT)    state_nxt = DONE;
         DONE:    if (out_ready)          state_nxt = IDLE;
         default:                         state_nxt = IDLE;
      endcase
   end

   // borrow_reg carries the captured borrow_in into chunk 0 and then the
   // running inter-chunk borrow; after the last chunk it is the final borrow.
   always_ff @(posedge clk) begin
      if (rst) begin
         a_reg      <= '0;
         b_reg      <= '0;
         diff_reg   <= '0;
         borrow_reg <= 1'b0;
         cnt        <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  a_reg      <= bits_a;
                  b_reg      <= bits_b;
                  borrow_reg <= borrow_in;
                  cnt        <= '0;
               end
            end
            RUN: begin
               diff_reg[cnt*CHUNK +: CHUNK] <= d_chunk;
               borrow_reg                   <= borrow_nxt;
               cnt                          <= cnt + 1'b1;
            end
            default: ;
         endcase
      end
   end

   // Flags are only meaningful once the full result exists, so they are held low outside DONE.
   always_comb begin
      in_ready   = (state == IDLE);
      out_valid  = (state == DONE);
      diff       = diff_reg;
      borrow_out = out_valid && borrow_reg;
      zero       = out_valid && (diff_reg == '0);
      overflow   = out_valid && (a_reg[MSB] != b_reg[MSB]) && (diff_reg[MSB] != a_reg[MSB]);
   end

endmodule

// File: tb/tb_serial_subtractor.sv
module tb_serial_subtractor;

   localparam int M = 1;   // instance with CHUNK = 2 used for directed tests

   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] bits_a, bits_b;
   logic       borrow_in;
   logic       in_valid_v  [4];
   logic       out_ready_v [4];
   logic       in_ready_v  [4];
   logic       out_valid_v [4];
   logic       borrow_out_v[4];
   logic       zero_v      [4];
   logic       overflow_v  [4];
   logic [7:0] diff_v      [4];

   int checks = 0;
   int passed = 0;

   always #5 clk = ~clk;

   for (genvar g = 0; g < 4; g++) begin : g_dut
      serial_subtractor #(
         .BITWIDTH (8),
         .CHUNK    (1 << g)
      ) u_dut (
         .clk        (clk),
         .rst        (rst),
         .bits_a     (bits_a),
         .bits_b     (bits_b),
         .borrow_in  (borrow_in),
         .in_valid   (in_valid_v[g]),
         .in_ready   (in_ready_v[g]),
         .diff       (diff_v[g]),
         .borrow_out (borrow_out_v[g]),
         .zero       (zero_v[g]),
         .overflow   (overflow_v[g]),
         .out_valid  (out_valid_v[g]),
         .out_ready  (out_ready_v[g])
      );
   end

   task automatic test_reset();
      rst       = 1'b1;
      bits_a    = 8'h00;
      bits_b    = 8'h00;
      borrow_in = 1'b0;
      for (int i = 0; i < 4; i++) begin
         in_valid_v[i]  = 1'b0;
         out_ready_v[i] = (i != M);
      end
      @(posedge clk); @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      checks++;
      if ({in_ready_v[M], out_valid_v[M], diff_v[M], borrow_out_v[M], zero_v[M], overflow_v[M]} !== {1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0})
         $display("FAIL reset_state: rdy=%b vld=%b diff=%h bo=%b z=%b ov=%b, expected rdy=1 vld=0 diff=00 bo=0 z=0 ov=0",
                  in_ready_v[M], out_valid_v[M], diff_v[M], borrow_out_v[M], zero_v[M], overflow_v[M]);
      else passed++;
   endtask

   // Handshake one operation into instance M, scramble operands afterwards,
   // check latency and results; optionally pop the result.
   task automatic run_main(input logic [7:0] a, input logic [7:0] b, input logic bin,
                           input logic [7:0] ed, input logic eb, input logic ez, input logic eo,
                           input string name, input bit pop);
      int w;
      int lat;
      w = 0;
      while (!in_ready_v[M] && w < 20) begin
         @(negedge clk); w++;
      end
      checks++;
      if (in_ready_v[M] !== 1'b1) $display("FAIL %s_ready: in_ready=%b, expected 1", name, in_ready_v[M]);
      else passed++;
      bits_a = a; bits_b = b; borrow_in = bin; in_valid_v[M] = 1'b1;
      @(posedge clk);
      @(negedge clk);
      in_valid_v[M] = 1'b0;
      bits_a = ~a; bits_b = ~b; borrow_in = ~bin;
      lat = 0;
      while (!out_valid_v[M] && lat < 20) begin
         @(posedge clk); @(negedge clk); lat++;
      end
      checks++;
      if (lat != 4) $display("FAIL %s_latency: got %0d cycles, expected 4", name, lat);
      else passed++;
      checks++;
      if ({diff_v[M], borrow_out_v[M], zero_v[M], overflow_v[M], in_ready_v[M]} !== {ed, eb, ez, eo, 1'b0})
         $display("FAIL %s_result: diff=%h bo=%b z=%b ov=%b rdy=%b, expected diff=%h bo=%b z=%b ov=%b rdy=0",
                  name, diff_v[M], borrow_out_v[M], zero_v[M], overflow_v[M], in_ready_v[M], ed, eb, ez, eo);
      else passed++;
      if (pop) begin
         out_ready_v[M] = 1'b1;
         @(posedge clk);
         @(negedge clk);
         out_ready_v[M] = 1'b0;
      end
   endtask

   task automatic test_basic();
      run_main(8'h35, 8'h12, 1'b0, 8'h23, 1'b0, 1'b0, 1'b0, "basic_35_12", 1'b1);
      run_main(8'h00, 8'h01, 1'b0, 8'hFF, 1'b1, 1'b0, 1'b0, "underflow_00_01", 1'b1);
      run_main(8'h12, 8'h11, 1'b1, 8'h00, 1'b0, 1'b1, 1'b0, "zero_12_11_b1", 1'b1);
      run_main(8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b0, 1'b1, "overflow_80_01", 1'b1);
   endtask

   task automatic test_back_to_back();
      run_main(8'hC3, 8'h3C, 1'b1, 8'h86, 1'b0, 1'b0, 1'b0, "hold_C3_3C", 1'b0);
      for (int i = 0; i < 5; i++) begin
         bits_a = 8'(i * 37); bits_b = 8'(i * 91); borrow_in = 1'(i);
         @(posedge clk); @(negedge clk);
         checks++;
         if ({out_valid_v[M], in_ready_v[M], diff_v[M], borrow_out_v[M], zero_v[M], overflow_v[M]} !== {1'b1, 1'b0, 8'h86, 1'b0, 1'b0, 1'b0})
            $display("FAIL hold_cycle%0d: vld=%b rdy=%b diff=%h bo=%b z=%b ov=%b, expected vld=1 rdy=0 diff=86 bo=0 z=0 ov=0",
                     i, out_valid_v[M], in_ready_v[M], diff_v[M], borrow_out_v[M], zero_v[M], overflow_v[M]);
         else passed++;
      end
      out_ready_v[M] = 1'b1;
      @(posedge clk); @(negedge clk);
      out_ready_v[M] = 1'b0;
      checks++;
      if ({in_ready_v[M], out_valid_v[M]} !== 2'b10)
         $display("FAIL release_idle: rdy=%b vld=%b, expected rdy=1 vld=0", in_ready_v[M], out_valid_v[M]);
      else passed++;
      run_main(8'h7F, 8'hFF, 1'b1, 8'h7F, 1'b1, 1'b0, 1'b0, "b2b_7F_FF_b1", 1'b1);
   endtask

   task automatic test_reset_mid_run();
      bits_a = 8'hFF; bits_b = 8'h01; borrow_in = 1'b0; in_valid_v[M] = 1'b1;
      @(posedge clk);
      @(negedge clk);
      in_valid_v[M] = 1'b0;
      @(posedge clk);
      @(negedge clk);
      // reset wins over a simultaneous in_valid
      rst = 1'b1; in_valid_v[M] = 1'b1;
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0; in_valid_v[M] = 1'b0;
      checks++;
      if ({out_valid_v[M], in_ready_v[M], diff_v[M]} !== {1'b0, 1'b1, 8'h00})
         $display("FAIL reset_mid_run: vld=%b rdy=%b diff=%h, expected vld=0 rdy=1 diff=00",
                  out_valid_v[M], in_ready_v[M], diff_v[M]);
      else passed++;
      run_main(8'hA5, 8'h5A, 1'b0, 8'h4B, 1'b0, 1'b0, 1'b1, "after_reset_A5_5A", 1'b1);
   endtask

   task automatic test_sweep();
      logic [7:0] a, b, ed;
      logic       bin, eb, ez, eo;
      logic [8:0] full;
      logic [3:0] done;
      int         w, cyc;
      for (int i = 0; i < 4; i++) out_ready_v[i] = 1'b1;
      for (int n = 0; n < 1000; n++) begin
         w = 0;
         while (!(in_ready_v[0] && in_ready_v[1] && in_ready_v[2] && in_ready_v[3]) && w < 20) begin
            @(negedge clk); w++;
         end
         a = 8'($urandom); b = 8'($urandom); bin = 1'($urandom);
         if (n < 4) begin a = 8'(n * 64); b = 8'(255 - n * 64); end
         full = {1'b0, a} - {1'b0, b} - {8'h00, bin};
         ed = full[7:0];
         eb = full[8];
         ez = (ed == 8'h00);
         eo = (a[7] != b[7]) && (ed[7] != a[7]);
         bits_a = a; bits_b = b; borrow_in = bin;
         for (int i = 0; i < 4; i++) in_valid_v[i] = 1'b1;
         @(posedge clk);
         @(negedge clk);
         for (int i = 0; i < 4; i++) in_valid_v[i] = 1'b0;
         bits_a = ~a; bits_b = b ^ 8'h5A; borrow_in = ~bin;
         done = 4'h0;
         cyc  = 0;
         while (done != 4'hF && cyc < 20) begin
            @(posedge clk); @(negedge clk); cyc++;
            for (int g = 0; g < 4; g++) begin
               if (!done[g] && out_valid_v[g]) begin
                  done[g] = 1'b1;
                  checks++;
                  if (cyc != (8 >> g) || {diff_v[g], borrow_out_v[g], zero_v[g], overflow_v[g]} !== {ed, eb, ez, eo})
                     $display("FAIL sweep_c%0d: a=%h b=%h bin=%b lat=%0d diff=%h bo=%b z=%b ov=%b, expected lat=%0d diff=%h bo=%b z=%b ov=%b",
                              1 << g, a, b, bin, cyc, diff_v[g], borrow_out_v[g], zero_v[g], overflow_v[g],
                              8 >> g, ed, eb, ez, eo);
                  else passed++;
               end
            end
         end
         for (int g = 0; g < 4; g++) begin
            if (!done[g]) begin
               checks++;
               $display("FAIL sweep_timeout_c%0d: out_valid=0 after %0d cycles, expected 1 after %0d", 1 << g, cyc, 8 >> g);
            end
         end
      end
   endtask

   initial begin
      @(negedge clk);
      test_reset();
      test_basic();
      test_back_to_back();
      test_reset_mid_run();
      test_sweep();
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule

// File: doc/serial_subtractor.md
SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

Interface
REQ-001 The block SHALL take parameter BITWIDTH, default 8, giving the operand and result width in bits.
REQ-002 The block SHALL take parameter CHUNK, default 2, giving the bits processed per cycle; BITWIDTH SHALL be an integer multiple of CHUNK, and N = BITWIDTH/CHUNK.
REQ-003 Port clk, input, 1 bit: single clock; all state SHALL update on its rising edge.
REQ-004 Port rst, input, 1 bit: reset, synchronous, active-high.
REQ-005 Port bits_a, input, BITWIDTH: minuend.
REQ-006 Port bits_b, input, BITWIDTH: subtrahend.
REQ-007 Port borrow_in, input, 1 bit: incoming borrow.
REQ-008 Port in_valid, input, 1 bit: operands are valid.
REQ-009 Port in_ready, output, 1 bit: block can accept operands.
REQ-010 Port diff, output, BITWIDTH: bits_a - bits_b - borrow_in, modulo 2^BITWIDTH.
REQ-011 Port borrow_out, output, 1 bit: high when bits_a < bits_b + borrow_in (unsigned).
REQ-012 Port zero, output, 1 bit: high when diff == 0.
REQ-013 Port overflow, output, 1 bit: two's-complement overflow of the signed subtraction.
REQ-014 Port out_valid, output, 1 bit: result outputs are valid.
REQ-015 Port out_ready, input, 1 bit: consumer accepts the result.

Function
REQ-016 The FSM SHALL have exactly three states: IDLE, RUN and DONE.
REQ-017 in_ready SHALL be high only in IDLE, and out_valid SHALL be high only in DONE.
REQ-018 In IDLE, when in_valid is high, the block SHALL capture bits_a, bits_b and borrow_in, clear the chunk counter and go to RUN.
REQ-019 In RUN, each cycle SHALL process chunk k (bits k*CHUNK+CHUNK-1 .. k*CHUNK) using the registered borrow, write that diff chunk and update the borrow, LSB chunk first.
REQ-020 RUN SHALL last exactly N cycles; after the edge that processes chunk N-1, the state SHALL be DONE.
REQ-021 Latency: for an input handshake at edge t, out_valid SHALL first be high after edge t+N.
REQ-022 Per chunk, the block SHALL compute diff_chunk = a_chunk - b_chunk - borrow mod 2^CHUNK, with borrow_next = (a_chunk < b_chunk + borrow).
REQ-023 overflow SHALL equal (a[MSB] != b[MSB]) && (diff[MSB] != a[MSB]), evaluated on the final result.
REQ-024 zero SHALL be derived from the complete diff register and SHALL be valid whenever out_valid is high.
REQ-025 In DONE, diff, borrow_out, zero and overflow SHALL hold stable until out_valid && out_ready.
REQ-026 On out_valid && out_ready, the block SHALL return to IDLE; in_ready SHALL be high the following cycle, so there is one bubble between results.
REQ-027 Changes on the operand inputs outside the IDLE handshake cycle SHALL have no effect on the result.
REQ-028 The block SHALL accept CHUNK == BITWIDTH (N = 1, single RUN cycle).

Reset
REQ-029 When rst is high at a clock edge, the state SHALL become IDLE and any in-progress operation SHALL be discarded, including in RUN or DONE.
REQ-030 Reset values: diff = 0, borrow_out = 0, zero = 0, overflow = 0, out_valid = 0, in_ready = 1 (in the cycle after reset), chunk counter = 0, operand registers = 0.
REQ-031 rst SHALL take priority over in_valid and out_ready in the same cycle.

Structure
REQ-032 A shared package SHALL hold the state enumeration (IDLE, RUN, DONE) and the default values of BITWIDTH and CHUNK.
REQ-033 The per-chunk arithmetic SHALL be a combinational sub-module sub_chunk (CHUNK-bit a, b and borrow in; diff and borrow out) instantiated once.
REQ-034 The chunk counter width SHALL be clog2(N), with a minimum of 1 bit.

Verification
REQ-035 BITWIDTH=8, CHUNK=2: a=0x35, b=0x12, bin=0 -> diff=0x23, borrow_out=0, zero=0, overflow=0, out_valid exactly 4 cycles after accept.
REQ-036 a=0x00, b=0x01, bin=0 -> diff=0xFF, borrow_out=1, overflow=0; a=0x12, b=0x11, bin=1 -> diff=0x00, zero=1, borrow_out=0.
REQ-037 a=0x80, b=0x01, bin=0 -> diff=0x7F, overflow=1, borrow_out=0.
REQ-038 Hold out_ready low for 5 cycles in DONE -> outputs stable and in_ready low throughout; release -> IDLE the next cycle, then a back-to-back operation completes correctly.
REQ-039 Assert rst in RUN cycle 2 -> next cycle out_valid=0, in_ready=1, diff=0; a fresh operation then gives the correct result.
REQ-040 A constrained-random sweep over 1000 operand sets, with CHUNK in {1, 2, 4, 8}, SHALL match a - b - bin in a reference model for diff and all flags.
